keycode_decoder: RTL and testbench
==================================

Name: keycode_decoder

Overview:
- Consumes the USB HID keycode bytes that the NIOS II software writes through the keycode PIO.
- Translates them into frame-aligned control signals for player, npc, projectile and stage_control: movement levels, single-cycle shoot pulses with per-shooter cooldown, a Fight pulse and a Restart level.
- Replaces the temporary SW/KEY-based controls in the top level.
- Sits between faculty_fighter_soc (keycode_export) and the game-logic blocks.

Parameters:
- NUM_KEYS, 2, number of simultaneous key slots; keycode is 8*NUM_KEYS bits, slot 0 in bits [7:0].
- COOLDOWN_FRAMES, 30, frames a shooter is blocked after each shot (0 allowed).

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  VGA_VS; its rising edge defines a frame tick
- keycode  in  8*NUM_KEYS  HID keycodes from NIOS; 0x00 means empty slot
- shoot_enable  in  1  high only in battle (battle_l); gates shoot pulses
- Player_Up / Player_Left / Player_Right  out  1  each, movement levels
- NPC_Up / NPC_Left / NPC_Right  out  1  each, movement levels
- player_shoot / npc_shoot  out  1  each, one-Clk shoot pulses
- Fight  out  1  one-Clk pulse to stage_control
- Restart  out  1  level to stage_control

Behaviour:
- Reset (Reset=0, asynchronous): all outputs 0; sync registers 0; previous-frame key state 0; both shoot FSMs in READY; cooldown counters 0.
- Synchronisation:
  - keycode passes through a 2-flop register chain.
  - frame_clk passes through a 3-flop chain; tick = one-Clk pulse on the synced rising edge.
- Decode is combinational from synced keycode. An action is pressed if any slot equals its code; 0x00 slots are ignored; duplicate codes are harmless.
- Key map:
  - Player: W 0x1A up, A 0x04 left, D 0x07 right, Space 0x2C shoot.
  - NPC: Up arrow 0x52 up, Left arrow 0x50 left, Right arrow 0x4F right, Keypad-0 0x62 shoot.
  - Stage: Enter 0x28 Fight, R 0x15 Restart.
- Movement and Restart outputs are registered only on tick, so they are constant within a frame.
  - Latency: keycode change → output update in the Clk after the first tick occurring ≥2 Clk after the change.
  - Left and Right both pressed for one character → both outputs 0; Up is unaffected.
- Press edge for Fight and shoot: pressed at this tick AND not pressed at the previous tick; previous state is captured each tick.
- Fight: 1 for exactly the Clk cycle following the tick that detects its press edge. Not gated by shoot_enable.
- Shoot FSM, one per shooter; counter width max(1, clog2(COOLDOWN_FRAMES+1)); all transitions happen only on tick.
  - READY: press edge AND shoot_enable → shoot pulse 1 Clk; counter = COOLDOWN_FRAMES; go to COOLDOWN. A press edge with shoot_enable=0 is discarded; it does not fire later.
  - COOLDOWN: if counter=0, go to WAIT_RELEASE when still pressed, else READY; otherwise decrement. With COOLDOWN_FRAMES=0, COOLDOWN lasts exactly one tick.
  - WAIT_RELEASE: not pressed → READY.
  - Shoot pulses are independent per shooter; both may pulse in the same cycle.
- Reset asserted mid-cooldown clears the FSM to READY immediately.
- Keycode changes between ticks are invisible; a key held for less than one frame may be missed. This is accepted.

Optional Feature:
- Macro: KEYCODE_AUTOFIRE_EN
- Defined:
  - COOLDOWN always returns to READY at counter=0; WAIT_RELEASE is unused.
  - READY fires on pressed level (not edge) when shoot_enable=1.
  - A held shoot key fires once every COOLDOWN_FRAMES+1 ticks.
- Undefined: behaviour exactly as above; each shot requires release and re-press.

Test Plan:
1. Reset low with keycode=0x1A2C → all outputs 0. Release reset and send 2 ticks → Player_Up=1; player_shoot pulses once (1 Clk) after the first tick; no further pulse while held.
2. keycode=0x0004 then 0x0704 → Player_Left=1 on the next tick, then Player_Left=0 and Player_Right=0 while both are held.
3. COOLDOWN_FRAMES=3, shoot_enable=1. Press 0x62, release after 1 tick, re-press every tick → npc_shoot pulses at ticks 1 and 6 only (cooldown 3, exit at tick 5, edge at tick 6). Player outputs stay 0.
4. shoot_enable=0, press Space, then raise shoot_enable while held → no pulse. Release and re-press → pulse on the next tick.
5. keycode=0x2815 held 3 ticks → Fight pulses once for 1 Clk; Restart=1 from the first tick until the tick after release. Assert Reset mid-frame → Restart=0 asynchronously.
6. KEYCODE_AUTOFIRE_EN, COOLDOWN_FRAMES=2, Space held 9 ticks → player_shoot pulses at ticks 1, 4 and 7.

Source files
------------

// File: rtl/keycode_decoder_if.sv
// keycode_decoder_if: bundles the keycode PIO, frame strobe and battle enable
// coming from the SoC side together with the control outputs toward the game
// logic (player, npc, projectile, stage_control).
//   master : drives frame_clk, keycode, shoot_enable; observes the controls
//   slave  : the decoder; consumes the inputs and drives the controls
interface keycode_decoder_if #(
  parameter int unsigned NUM_KEYS = 2
);
  logic                  frame_clk;
  logic [8*NUM_KEYS-1:0] keycode;
  logic                  shoot_enable;

  logic                  Player_Up;
  logic                  Player_Left;
  logic                  Player_Right;
  logic                  NPC_Up;
  logic                  NPC_Left;
  logic                  NPC_Right;
  logic                  player_shoot;
  logic                  npc_shoot;
  logic                  Fight;
  logic                  Restart;

  modport master (
    output frame_clk, keycode, shoot_enable,
    input  Player_Up, Player_Left, Player_Right,
    input  NPC_Up, NPC_Left, NPC_Right,
    input  player_shoot, npc_shoot, Fight, Restart
  );

  modport slave (
    input  frame_clk, keycode, shoot_enable,
    output Player_Up, Player_Left, Player_Right,
    output NPC_Up, NPC_Left, NPC_Right,
    output player_shoot, npc_shoot, Fight, Restart
  );
endinterface

// File: rtl/keycode_decoder.sv
// keycode_decoder: turns the USB HID keycodes written by the NIOS II into
// frame-aligned game controls.
//   Clk    : system clock (50 MHz)
//   Reset  : asynchronous, active-low reset
//   bus    : keycode_decoder_if.slave
//            in  frame_clk (VGA_VS), keycode (8*NUM_KEYS, slot 0 in [7:0]),
//                shoot_enable (battle only)
//            out Player_/NPC_ Up/Left/Right levels, player_shoot/npc_shoot
//                one-Clk pulses, Fight one-Clk pulse, Restart level
// Parameters: NUM_KEYS (key slots), COOLDOWN_FRAMES (frames a shooter is
// blocked after each shot, 0 allowed).
// Optional build macro KEYCODE_AUTOFIRE_EN: a held shoot key re-fires every
// COOLDOWN_FRAMES+1 frames instead of requiring release and re-press.
module keycode_decoder #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input logic              Clk,
  input logic              Reset,
  keycode_decoder_if.slave bus
);

  localparam int unsigned KW = 8 * NUM_KEYS;
  localparam int unsigned CW = (COOLDOWN_FRAMES == 0) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
  localparam int unsigned NSH = 2;  // shooter 0 = player, 1 = npc

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_KP0   = 8'h62;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_R     = 8'h15;

  typedef enum logic [1:0] {
    SH_READY        = 2'd0,
    SH_COOLDOWN     = 2'd1,
    SH_WAIT_RELEASE = 2'd2
  } shoot_state_e;

  // Synchronisers
  logic [KW-1:0] kc_meta_q, kc_sync_q;
  logic [2:0]    fc_q;
  logic          tick_c;

  // Decoded key levels (from the synced keycode)
  logic p_up_c, p_left_c, p_right_c, p_shoot_c;
  logic n_up_c, n_left_c, n_right_c, n_shoot_c;
  logic fight_c, restart_c;
  logic [NSH-1:0] pressed_c;

  // Registered state and outputs
  logic [5:0]     move_q, move_d;          // {P_Up,P_Left,P_Right,N_Up,N_Left,N_Right}
  logic           restart_q, restart_d;
  logic           fight_q, fight_d;
  logic           fight_prev_q, fight_prev_d;
  logic [NSH-1:0] shoot_q, shoot_d;
`ifndef KEYCODE_AUTOFIRE_EN
  logic [NSH-1:0] shoot_prev_q, shoot_prev_d;
`endif
  shoot_state_e   st_q  [NSH];
  shoot_state_e   st_d  [NSH];
  logic [CW-1:0]  cnt_q [NSH];
  logic [CW-1:0]  cnt_d [NSH];

  // True when any non-empty slot carries the given code
  function automatic logic key_hit(input logic [KW-1:0] kc, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if ((kc[8*i +: 8] != 8'h00) && (kc[8*i +: 8] == code)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Frame tick: one-Clk pulse on the synced rising edge of frame_clk
  assign tick_c = fc_q[1] & ~fc_q[2];

  // Key decode
  always_comb begin
    p_up_c    = key_hit(kc_sync_q, KEY_W);
    p_left_c  = key_hit(kc_sync_q, KEY_A);
    p_right_c = key_hit(kc_sync_q, KEY_D);
    p_shoot_c = key_hit(kc_sync_q, KEY_SPACE);
    n_up_c    = key_hit(kc_sync_q, KEY_UP);
    n_left_c  = key_hit(kc_sync_q, KEY_LEFT);
    n_right_c = key_hit(kc_sync_q, KEY_RIGHT);
    n_shoot_c = key_hit(kc_sync_q, KEY_KP0);
    fight_c   = key_hit(kc_sync_q, KEY_ENTER);
    restart_c = key_hit(kc_sync_q, KEY_R);
    pressed_c = {n_shoot_c, p_shoot_c};
  end

  // Next-state: everything advances only on the frame tick
  always_comb begin
    move_d       = move_q;
    restart_d    = restart_q;
    fight_d      = 1'b0;
    fight_prev_d = fight_prev_q;
    shoot_d      = '0;
`ifndef KEYCODE_AUTOFIRE_EN
    shoot_prev_d = shoot_prev_q;
`endif
    for (int s = 0; s < int'(NSH); s++) begin
      st_d[s]  = st_q[s];
      cnt_d[s] = cnt_q[s];
    end

    if (tick_c) begin
      // Opposing directions cancel; Up is independent
      move_d = {p_up_c, p_left_c & ~p_right_c, p_right_c & ~p_left_c,
                n_up_c, n_left_c & ~n_right_c, n_right_c & ~n_left_c};
      restart_d    = restart_c;
      fight_d      = fight_c & ~fight_prev_q;
      fight_prev_d = fight_c;
`ifndef KEYCODE_AUTOFIRE_EN
      shoot_prev_d = pressed_c;
`endif

      for (int s = 0; s < int'(NSH); s++) begin
        case (st_q[s])
          SH_READY: begin
`ifdef KEYCODE_AUTOFIRE_EN
            if (pressed_c[s] && bus.shoot_enable) begin
`else
            // Edges seen while disabled are dropped, never deferred
            if (pressed_c[s] && !shoot_prev_q[s] && bus.shoot_enable) begin
`endif
              shoot_d[s] = 1'b1;
              cnt_d[s]   = CD_LOAD;
              st_d[s]    = SH_COOLDOWN;
            end
          end
          SH_COOLDOWN: begin
            if (cnt_q[s] == '0) begin
`ifdef KEYCODE_AUTOFIRE_EN
              // Refire on the exit tick itself so a held key shoots
              // every COOLDOWN_FRAMES+1 frames
              if (pressed_c[s] && bus.shoot_enable) begin
                shoot_d[s] = 1'b1;
                cnt_d[s]   = CD_LOAD;
              end else begin
                st_d[s] = SH_READY;
              end
`else
              st_d[s] = pressed_c[s] ? SH_WAIT_RELEASE : SH_READY;
`endif
            end else begin
              cnt_d[s] = cnt_q[s] - CW'(1);
            end
          end
          SH_WAIT_RELEASE: begin
`ifdef KEYCODE_AUTOFIRE_EN
            st_d[s] = SH_READY;
`else
            if (!pressed_c[s]) st_d[s] = SH_READY;
`endif
          end
          default: st_d[s] = SH_READY;
        endcase
      end
    end
  end

  // All registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      kc_meta_q    <= '0;
      kc_sync_q    <= '0;
      fc_q         <= '0;
      move_q       <= '0;
      restart_q    <= 1'b0;
      fight_q      <= 1'b0;
      fight_prev_q <= 1'b0;
      shoot_q      <= '0;
`ifndef KEYCODE_AUTOFIRE_EN
      shoot_prev_q <= '0;
`endif
      for (int s = 0; s < int'(NSH); s++) begin
        st_q[s]  <= SH_READY;
        cnt_q[s] <= '0;
      end
    end else begin
      kc_meta_q    <= bus.keycode;
      kc_sync_q    <= kc_meta_q;
      fc_q         <= {fc_q[1:0], bus.frame_clk};
      move_q       <= move_d;
      restart_q    <= restart_d;
      fight_q      <= fight_d;
      fight_prev_q <= fight_prev_d;
      shoot_q      <= shoot_d;
`ifndef KEYCODE_AUTOFIRE_EN
      shoot_prev_q <= shoot_prev_d;
`endif
      for (int s = 0; s < int'(NSH); s++) begin
        st_q[s]  <= st_d[s];
        cnt_q[s] <= cnt_d[s];
      end
    end
  end

  assign bus.Player_Up    = move_q[5];
  assign bus.Player_Left  = move_q[4];
  assign bus.Player_Right = move_q[3];
  assign bus.NPC_Up       = move_q[2];
  assign bus.NPC_Left     = move_q[1];
  assign bus.NPC_Right    = move_q[0];
  assign bus.player_shoot = shoot_q[0];
  assign bus.npc_shoot    = shoot_q[1];
  assign bus.Fight        = fight_q;
  assign bus.Restart      = restart_q;

endmodule

// File: tb/tb_keycode_decoder.sv
// tb_keycode_decoder: directed vector table, reset corner sequences and a
// randomized run against a frame-level reference model.
module tb_keycode_decoder;

  localparam int NK = 2;
  localparam int CF = 3;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  keycode_decoder_if #(.NUM_KEYS(NK)) bus ();

  keycode_decoder #(
    .NUM_KEYS(NK),
    .COOLDOWN_FRAMES(CF)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse-cycle counters, sampled just after each rising edge
  int ps_cnt = 0, ns_cnt = 0, fi_cnt = 0;
  always @(posedge Clk) begin
    #1;
    if (bus.player_shoot) ps_cnt++;
    if (bus.npc_shoot)    ns_cnt++;
    if (bus.Fight)        fi_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete frame: settle keycode, raise frame_clk, sample, lower
  task automatic do_frame(input logic [8*NK-1:0] kc, input logic en,
                          output logic [6:0] lv, output int ps, output int ns, output int fi);
    @(negedge Clk);
    bus.keycode      = kc;
    bus.shoot_enable = en;
    ps_cnt = 0; ns_cnt = 0; fi_cnt = 0;
    repeat (3) @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    lv = {bus.Player_Up, bus.Player_Left, bus.Player_Right,
          bus.NPC_Up, bus.NPC_Left, bus.NPC_Right, bus.Restart};
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    ps = ps_cnt; ns = ns_cnt; fi = fi_cnt;
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  // ---------------- reference model (one call per frame) ----------------
  int       m_t;
  int       m_last [2];
  bit       m_prev [2];
  bit       m_fprev;

  function automatic bit hit(input logic [8*NK-1:0] kc, input logic [7:0] code);
    for (int i = 0; i < NK; i++) if (kc[8*i +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int s = 0; s < 2; s++) begin m_last[s] = -1000; m_prev[s] = 1'b0; end
    m_fprev = 1'b0;
  endtask

  task automatic model_frame(input logic [8*NK-1:0] kc, input logic en,
                             output logic [6:0] lv, output int ps, output int ns, output int fi);
    logic [7:0] sc [2];
    int fire [2];
    bit p;
    sc[0] = 8'h2C; sc[1] = 8'h62;
    m_t++;
    for (int s = 0; s < 2; s++) begin
      p = hit(kc, sc[s]);
`ifdef KEYCODE_AUTOFIRE_EN
      fire[s] = (p && en && (m_t >= m_last[s] + CF + 1)) ? 1 : 0;
`else
      // Shots are spaced more than CF+1 frames apart and need a fresh press
      fire[s] = (p && !m_prev[s] && en && (m_t > m_last[s] + CF + 1)) ? 1 : 0;
`endif
      if (fire[s] != 0) m_last[s] = m_t;
      m_prev[s] = p;
    end
    ps = fire[0];
    ns = fire[1];
    fi = (hit(kc, 8'h28) && !m_fprev) ? 1 : 0;
    m_fprev = hit(kc, 8'h28);
    lv = {hit(kc, 8'h1A), hit(kc, 8'h04) && !hit(kc, 8'h07), hit(kc, 8'h07) && !hit(kc, 8'h04),
          hit(kc, 8'h52), hit(kc, 8'h50) && !hit(kc, 8'h4F), hit(kc, 8'h4F) && !hit(kc, 8'h50),
          hit(kc, 8'h15)};
  endtask

  // ---------------- directed vector table ----------------
  // lv = {P_Up,P_Left,P_Right,N_Up,N_Left,N_Right,Restart}
  typedef struct {
    logic [15:0] kc;
    logic        en;
    logic [6:0]  lv;
    int          ps;
    int          ns;
    int          fi;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [6:0] lv, elv;
    int ps, ns, fi, eps, ens, efi;
    logic [8*NK-1:0] kc;
    logic [7:0] pool [12];
    logic       en;

`ifdef KEYCODE_AUTOFIRE_EN
    for (int i = 0; i < 9; i++)
      tbl.push_back('{16'h002C, 1'b1, 7'b0000000, ((i % 4) == 0) ? 1 : 0, 0, 0});
    tbl.push_back('{16'h2815, 1'b1, 7'b0000001, 0, 0, 1});
    tbl.push_back('{16'h0704, 1'b1, 7'b0000000, 0, 0, 0});
`else
    tbl.push_back('{16'h1A2C, 1'b1, 7'b1000000, 1, 0, 0});
    tbl.push_back('{16'h1A2C, 1'b1, 7'b1000000, 0, 0, 0});
    tbl.push_back('{16'h0004, 1'b1, 7'b0100000, 0, 0, 0});
    tbl.push_back('{16'h0704, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h0007, 1'b1, 7'b0010000, 0, 0, 0});
    tbl.push_back('{16'h2C00, 1'b1, 7'b0000000, 1, 0, 0});
    tbl.push_back('{16'h0000, 1'b0, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h002C, 1'b0, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h002C, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h0000, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h002C, 1'b1, 7'b0000000, 1, 0, 0});
    tbl.push_back('{16'h6200, 1'b1, 7'b0000000, 0, 1, 0});
    tbl.push_back('{16'h0000, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h0062, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h0000, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h0062, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h0062, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h0000, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h622C, 1'b1, 7'b0000000, 1, 1, 0});
    tbl.push_back('{16'h2815, 1'b1, 7'b0000001, 0, 0, 1});
    tbl.push_back('{16'h2815, 1'b1, 7'b0000001, 0, 0, 0});
    tbl.push_back('{16'h2815, 1'b1, 7'b0000001, 0, 0, 0});
    tbl.push_back('{16'h0052, 1'b1, 7'b0001000, 0, 0, 0});
    tbl.push_back('{16'h5051, 1'b1, 7'b0000100, 0, 0, 0});
    tbl.push_back('{16'h4F50, 1'b1, 7'b0000000, 0, 0, 0});
    tbl.push_back('{16'h4F00, 1'b1, 7'b0000010, 0, 0, 0});
    tbl.push_back('{16'h2800, 1'b1, 7'b0000000, 0, 0, 1});
    tbl.push_back('{16'h0000, 1'b1, 7'b0000000, 0, 0, 0});
`endif

    // Reset held with keys pressed and frame_clk toggling: outputs stay 0
    Reset            = 1'b0;
    bus.frame_clk    = 1'b0;
    bus.keycode      = 16'h1A2C;
    bus.shoot_enable = 1'b1;
    repeat (3) @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    check("reset_outputs",
          32'({bus.Player_Up, bus.Player_Left, bus.Player_Right, bus.NPC_Up, bus.NPC_Left,
               bus.NPC_Right, bus.player_shoot, bus.npc_shoot, bus.Fight, bus.Restart}), 32'h0);
    Reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      do_frame(tbl[i].kc, tbl[i].en, lv, ps, ns, fi);
      check($sformatf("vec%0d_levels", i), 32'(lv), 32'(tbl[i].lv));
      check($sformatf("vec%0d_player_shoot", i), 32'(ps), 32'(tbl[i].ps));
      check($sformatf("vec%0d_npc_shoot", i), 32'(ns), 32'(tbl[i].ns));
      check($sformatf("vec%0d_fight", i), 32'(fi), 32'(tbl[i].fi));
    end

    // Restart cleared asynchronously by a mid-cycle reset
    do_frame(16'h0015, 1'b1, lv, ps, ns, fi);
    check("restart_set", 32'(lv), 32'h01);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("restart_async_clear", 32'(bus.Restart), 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // Reset in the middle of a cooldown re-arms the shooter at once
    do_frame(16'h002C, 1'b1, lv, ps, ns, fi);
    check("cool_first_shot", 32'(ps), 32'h1);
    do_frame(16'h0000, 1'b1, lv, ps, ns, fi);
    pulse_reset();
    do_frame(16'h002C, 1'b1, lv, ps, ns, fi);
    check("cool_reset_rearm", 32'(ps), 32'h1);

    // Randomized frames against the reference model
    pool = '{8'h00, 8'h1A, 8'h04, 8'h07, 8'h2C, 8'h52, 8'h50, 8'h4F, 8'h62, 8'h28, 8'h15, 8'h33};
    pulse_reset();
    model_reset();
    kc = '0;
    for (int f = 0; f < 300; f++) begin
      for (int s = 0; s < NK; s++)
        if ($urandom_range(0, 1) == 0) kc[8*s +: 8] = pool[$urandom_range(0, 11)];
      en = ($urandom_range(0, 7) != 0);
      model_frame(kc, en, elv, eps, ens, efi);
      do_frame(kc, en, lv, ps, ns, fi);
      check($sformatf("rnd%0d_levels kc=%h", f, kc), 32'(lv), 32'(elv));
      check($sformatf("rnd%0d_player_shoot kc=%h", f, kc), 32'(ps), 32'(eps));
      check($sformatf("rnd%0d_npc_shoot kc=%h", f, kc), 32'(ns), 32'(ens));
      check($sformatf("rnd%0d_fight kc=%h", f, kc), 32'(fi), 32'(efi));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
